// File: rtl/dest_reg_tracker.sv
// Destination-register scoreboard for the EX/MEM/WB stages: load-use stall, operand forwarding selects, pending-write mask.
// Optional saturating stall counter enabled by defining DEST_REG_TRACKER_STALL_CNT_EN.
module dest_reg_tracker #(
  parameter int ADDR_W = 5,
  parameter int NSTAGE = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dst,
  input  logic                     issue_we,
  input  logic                     issue_is_load,
  input  logic [ADDR_W-1:0]        src_a,
  input  logic [ADDR_W-1:0]        src_b,
  input  logic                     flush,
  output logic                     stall,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic [(2**ADDR_W)-1:0]   pending
`ifdef DEST_REG_TRACKER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int NREG = 2**ADDR_W;

  // Stage index 0 = EX, 1 = MEM, 2 = WB.
  logic [NSTAGE-1:0]             v_q, v_d;
  logic [NSTAGE-1:0]             we_q, we_d;
  logic [NSTAGE-1:0]             ld_q, ld_d;
  logic [NSTAGE-1:0][ADDR_W-1:0] dst_q, dst_d;
  logic [NSTAGE-1:0]             live_s;

  // Youngest live producer wins; an EX load cannot forward yet and is covered by the stall.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0]             src,
    input logic [NSTAGE-1:0]             live,
    input logic                          ex_ld,
    input logic [NSTAGE-1:0][ADDR_W-1:0] dst
  );
    logic [1:0] sel;
    sel = 2'b00;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (live[i] && (dst[i] == src) && !((i == 0) && ex_ld)) begin
        sel = 2'(i + 1);
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Liveness: register 0 is never a real write target.
  always_comb begin
    for (int i = 0; i < NSTAGE; i++) begin
      live_s[i] = v_q[i] & we_q[i] & (dst_q[i] != {ADDR_W{1'b0}});
    end
  end

  // Load-use hazard on the entry currently in EX; flush overrides it.
  always_comb begin
    stall = issue_valid & live_s[0] & ld_q[0]
          & ((dst_q[0] == src_a) | (dst_q[0] == src_b)) & ~flush;
  end

  // Forwarding selects for both operands.
  always_comb begin
    fwd_a = fwd_sel(src_a, live_s, ld_q[0], dst_q);
    fwd_b = fwd_sel(src_b, live_s, ld_q[0], dst_q);
  end

  // Pending-write mask from stage registers only.
  always_comb begin
    pending = {NREG{1'b0}};
    for (int i = 0; i < NSTAGE; i++) begin
      pending = pending | ({{(NREG-1){1'b0}}, live_s[i]} << dst_q[i]);
    end
  end

  // Next stage contents: WB always takes MEM; flush bubbles EX and MEM, stall bubbles EX.
  always_comb begin
    v_d[2]   = v_q[1];
    we_d[2]  = we_q[1];
    ld_d[2]  = ld_q[1];
    dst_d[2] = dst_q[1];
    if (flush) begin
      v_d[1]   = 1'b0;
      we_d[1]  = 1'b0;
      ld_d[1]  = 1'b0;
      dst_d[1] = {ADDR_W{1'b0}};
      v_d[0]   = 1'b0;
      we_d[0]  = 1'b0;
      ld_d[0]  = 1'b0;
      dst_d[0] = {ADDR_W{1'b0}};
    end else if (stall) begin
      v_d[1]   = v_q[0];
      we_d[1]  = we_q[0];
      ld_d[1]  = ld_q[0];
      dst_d[1] = dst_q[0];
      v_d[0]   = 1'b0;
      we_d[0]  = 1'b0;
      ld_d[0]  = 1'b0;
      dst_d[0] = {ADDR_W{1'b0}};
    end else begin
      v_d[1]   = v_q[0];
      we_d[1]  = we_q[0];
      ld_d[1]  = ld_q[0];
      dst_d[1] = dst_q[0];
      v_d[0]   = issue_valid;
      we_d[0]  = issue_we;
      ld_d[0]  = issue_is_load;
      dst_d[0] = issue_dst;
    end
  end

  // Stage registers; reset drops every in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= {NSTAGE{1'b0}};
      we_q  <= {NSTAGE{1'b0}};
      ld_q  <= {NSTAGE{1'b0}};
      dst_q <= {(NSTAGE*ADDR_W){1'b0}};
    end else begin
      v_q   <= v_d;
      we_q  <= we_d;
      ld_q  <= ld_d;
      dst_q <= dst_d;
    end
  end

`ifdef DEST_REG_TRACKER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled edges.
  always_comb begin
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Table-driven bench for dest_reg_tracker: per-cycle vectors through a scoreboard queue plus reset corner cases.
module tb_dest_reg_tracker;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        issue_we;
  logic        issue_is_load;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] pending;
`ifdef DEST_REG_TRACKER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  dest_reg_tracker #(.ADDR_W(5), .NSTAGE(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_dst    (issue_dst),
    .issue_we     (issue_we),
    .issue_is_load(issue_is_load),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .stall        (stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .pending      (pending)
`ifdef DEST_REG_TRACKER_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  dst;
    logic        we;
    logic        ld;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic        fl;
    logic        e_stall;
    logic [1:0]  e_fa;
    logic [1:0]  e_fb;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(int v, int dst, int we, int ld, int sa, int sb_i, int fl,
                              int e_st, int e_fa, int e_fb, logic [31:0] e_pend);
    vec_t r;
    r.v = 1'(v); r.dst = 5'(dst); r.we = 1'(we); r.ld = 1'(ld);
    r.sa = 5'(sa); r.sb = 5'(sb_i); r.fl = 1'(fl);
    r.e_stall = 1'(e_st); r.e_fa = 2'(e_fa); r.e_fb = 2'(e_fb); r.e_pend = e_pend;
    return r;
  endfunction

  function automatic logic [31:0] bit_of(int n);
    logic [31:0] one;
    one = 32'h1;
    return one << n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic drive(vec_t t);
    issue_valid = t.v; issue_dst = t.dst; issue_we = t.we; issue_is_load = t.ld;
    src_a = t.sa; src_b = t.sb; flush = t.fl;
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_dst = 5'd0; issue_we = 1'b0; issue_is_load = 1'b0;
    src_a = 5'd0; src_b = 5'd0; flush = 1'b0;

    // ALU chain: dst=3 travels EX -> MEM -> WB -> retired
    tbl.push_back(mk(1, 3, 1, 0,  0, 0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0,  3, 0, 0,  0, 1, 0, bit_of(3)));
    tbl.push_back(mk(0, 0, 0, 0,  0, 3, 0,  0, 0, 2, bit_of(3)));
    tbl.push_back(mk(0, 0, 0, 0,  0, 3, 0,  0, 0, 3, bit_of(3)));
    tbl.push_back(mk(0, 0, 0, 0,  0, 3, 0,  0, 0, 0, 32'h0));
    // Load-use: load dst=7, consumer dst=8 reads r7 and is held for one cycle
    tbl.push_back(mk(1, 7, 1, 1,  0, 0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 8, 1, 0,  0, 7, 0,  1, 0, 0, bit_of(7)));
    tbl.push_back(mk(1, 8, 1, 0,  0, 7, 0,  0, 0, 2, bit_of(7)));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, bit_of(7) | bit_of(8)));
    tbl.push_back(mk(0, 0, 0, 0,  8, 0, 0,  0, 2, 0, bit_of(8)));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, bit_of(8)));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0));
    // Register zero is never live
    tbl.push_back(mk(1, 0, 1, 0,  0, 0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0));
    // Flush with EX=6, MEM=4: only 4 survives into WB; issued dst=10 is dropped
    tbl.push_back(mk(1, 4, 1, 0,  0, 0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 6, 1, 0,  4, 0, 0,  0, 1, 0, bit_of(4)));
    tbl.push_back(mk(1, 10, 1, 0, 6, 4, 1,  0, 1, 2, bit_of(4) | bit_of(6)));
    tbl.push_back(mk(0, 0, 0, 0,  6, 4, 0,  0, 0, 3, bit_of(4)));
    tbl.push_back(mk(0, 0, 0, 0,  10, 4, 0, 0, 0, 0, 32'h0));
    // Same dst=9 twice: youngest wins, pending holds until both retire
    tbl.push_back(mk(1, 9, 1, 0,  0, 0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 9, 1, 0,  9, 0, 0,  0, 1, 0, bit_of(9)));
    tbl.push_back(mk(0, 0, 0, 0,  9, 0, 0,  0, 1, 0, bit_of(9)));
    tbl.push_back(mk(0, 0, 0, 0,  9, 0, 0,  0, 2, 0, bit_of(9)));
    tbl.push_back(mk(0, 0, 0, 0,  9, 0, 0,  0, 3, 0, bit_of(9)));
    tbl.push_back(mk(0, 0, 0, 0,  9, 0, 0,  0, 0, 0, 32'h0));
    // Load hazard coinciding with flush: stall forced low, load in EX not forwarded
    tbl.push_back(mk(1, 12, 1, 1, 0, 0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 13, 1, 0, 12, 0, 1, 0, 0, 0, bit_of(12)));
    tbl.push_back(mk(0, 0, 0, 0,  12, 0, 0, 0, 0, 0, 32'h0));
    // we=0 entry never forwards nor pends
    tbl.push_back(mk(1, 15, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0,  15, 15, 0, 0, 0, 0, 32'h0));

    // Outputs held quiet in reset
    #12;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_fwd",   {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("reset_pend",  pending, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d_stall", i), {31'd0, stall}, {31'd0, e.e_stall});
      chk($sformatf("row%0d_fwd_a", i), {30'd0, fwd_a}, {30'd0, e.e_fa});
      chk($sformatf("row%0d_fwd_b", i), {30'd0, fwd_b}, {30'd0, e.e_fb});
      chk($sformatf("row%0d_pend", i),  pending, e.e_pend);
    end

`ifdef DEST_REG_TRACKER_STALL_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd1);
`endif

    // Reset mid-stream: dst=5 in EX, then rst_n drops between edges
    @(negedge clk);
    issue_valid = 1'b1; issue_dst = 5'd5; issue_we = 1'b1; issue_is_load = 1'b0;
    src_a = 5'd0; src_b = 5'd0; flush = 1'b0;
    @(negedge clk);
    issue_valid = 1'b0; src_a = 5'd5; src_b = 5'd5;
    #1;
    chk("pre_rst_pend", pending, bit_of(5));
    chk("pre_rst_fwd_a", {30'd0, fwd_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pend", pending, 32'd0);
    chk("mid_rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
`ifdef DEST_REG_TRACKER_STALL_CNT_EN
    chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_pend", pending, 32'd0);
    chk("post_rst_fwd_a", {30'd0, fwd_a}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
